axi_lite_reg_bridge: RTL



---
 rtl/axi_lite_if.sv | 33 +++
 rtl/axi_lite_reg_bridge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R channels) with master and slave views.
interface axi_lite_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI-Lite slave that turns each write/read into one req/ready register-bus access,
// with fair write/read arbitration, per-request timeout and error propagation.
module axi_lite_reg_bridge #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    axi_lite_if.slave       s_axi,
    output logic            reg_req_o,
    output logic [AW-1:0]   reg_addr_o,
    output logic [DW/8-1:0] reg_we_o,
    output logic [DW-1:0]   reg_wdata_o,
    input  logic [DW-1:0]   reg_rdata_i,
    input  logic            reg_ready_i,
    input  logic            reg_err_i
);
    localparam int unsigned SW      = DW / 8;
    localparam int unsigned CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [AW-1:0] WORD_MASK   = ~AW'(3);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_e;

    state_e          state_q;
    logic            active_q;
    logic            aw_held_q;
    logic            w_held_q;
    logic            ar_held_q;
    logic            last_was_write_q;
    logic [AW-1:0]   awaddr_q;
    logic [AW-1:0]   araddr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   wstrb_q;
    logic [CW-1:0]   to_cnt_q;
    logic            bvalid_q;
    logic [1:0]      bresp_q;
    logic            rvalid_q;
    logic [1:0]      rresp_q;
    logic [DW-1:0]   rdata_q;

    logic idle_c;
    logic awready_c;
    logic wready_c;
    logic arready_c;
    logic wr_pend_c;
    logic rd_pend_c;
    logic pick_wr_c;
    logic timeout_c;

    // Channel acceptance only in IDLE; a partially captured write blocks new reads.
    assign idle_c    = active_q && (state_q == IDLE);
    assign awready_c = idle_c && !aw_held_q;
    assign wready_c  = idle_c && !w_held_q;
    assign arready_c = idle_c && !ar_held_q && !aw_held_q && !w_held_q;

    // Round-robin between a complete write and a pending read.
    assign wr_pend_c = aw_held_q && w_held_q;
    assign rd_pend_c = ar_held_q;
    assign pick_wr_c = wr_pend_c && (!rd_pend_c || !last_was_write_q);
    assign timeout_c = (TIMEOUT_CYCLES != 0) && (to_cnt_q == CW'(TO_LAST));

    assign s_axi.awready = awready_c;
    assign s_axi.wready  = wready_c;
    assign s_axi.arready = arready_c;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            active_q         <= 1'b0;
            aw_held_q        <= 1'b0;
            w_held_q         <= 1'b0;
            ar_held_q        <= 1'b0;
            last_was_write_q <= 1'b0;
            awaddr_q         <= '0;
            araddr_q         <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            to_cnt_q         <= '0;
            bvalid_q         <= 1'b0;
            bresp_q          <= RESP_OKAY;
            rvalid_q         <= 1'b0;
            rresp_q          <= RESP_OKAY;
            rdata_q          <= '0;
            reg_req_o        <= 1'b0;
            reg_addr_o       <= '0;
            reg_we_o         <= '0;
            reg_wdata_o      <= '0;
        end else begin
            active_q <= 1'b1;

            if (s_axi.awvalid && awready_c) begin
                awaddr_q  <= s_axi.awaddr & WORD_MASK;
                aw_held_q <= 1'b1;
            end
            if (s_axi.wvalid && wready_c) begin
                wdata_q  <= s_axi.wdata;
                wstrb_q  <= s_axi.wstrb;
                w_held_q <= 1'b1;
            end
            if (s_axi.arvalid && arready_c) begin
                araddr_q  <= s_axi.araddr & WORD_MASK;
                ar_held_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    to_cnt_q <= '0;
                    if (pick_wr_c) begin
                        last_was_write_q <= 1'b1;
                        if (wstrb_q == '0) begin
                            // Nothing to write downstream: answer OKAY directly.
                            bvalid_q <= 1'b1;
                            bresp_q  <= RESP_OKAY;
                            state_q  <= WR_RESP;
                        end else begin
                            reg_req_o   <= 1'b1;
                            reg_addr_o  <= awaddr_q;
                            reg_we_o    <= wstrb_q;
                            reg_wdata_o <= wdata_q;
                            state_q     <= WR_REQ;
                        end
                    end else if (rd_pend_c) begin
                        last_was_write_q <= 1'b0;
                        reg_req_o        <= 1'b1;
                        reg_addr_o       <= araddr_q;
                        reg_we_o         <= '0;
                        state_q          <= RD_REQ;
                    end
                end

                WR_REQ: begin
                    if (reg_ready_i) begin
                        reg_req_o <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= reg_err_i ? RESP_SLVERR : RESP_OKAY;
                        state_q   <= WR_RESP;
                    end else if (timeout_c) begin
                        reg_req_o <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= RESP_SLVERR;
                        state_q   <= WR_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + CW'(1);
                    end
                end

                WR_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end

                RD_REQ: begin
                    if (reg_ready_i) begin
                        reg_req_o <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= reg_err_i ? RESP_SLVERR : RESP_OKAY;
                        rdata_q   <= reg_rdata_i;
                        state_q   <= RD_RESP;
                    end else if (timeout_c) begin
                        reg_req_o <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= RESP_SLVERR;
                        rdata_q   <= '0;
                        state_q   <= RD_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + CW'(1);
                    end
                end

                RD_RESP: begin
                    if (s_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        ar_held_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
